// File: rtl/wb_pkg.sv
// Shared widths and the queued write-back entry type for the register-file write-back arbiter.
package wb_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Multi-cycle result queue: FIFO of write-back entries.
// Also exposes the per-slot valid bits and contents so the busy mask can be built.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  wb_entry_t             push_entry_i,
  input  logic                  pop_i,
  output logic                  full_o,
  output logic                  empty_o,
  output wb_entry_t             head_o,
  output logic      [DEPTH-1:0] valid_o,
  output wb_entry_t [DEPTH-1:0] entries_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic      [PTR_W-1:0] wptr_q;
  logic      [PTR_W-1:0] rptr_q;
  logic      [DEPTH-1:0] valid_q;
  wb_entry_t [DEPTH-1:0] mem_q;
  logic                  do_push;
  logic                  do_pop;

  // With in-order slots, the write slot being occupied means every slot is occupied.
  assign full_o    = valid_q[wptr_q];
  assign empty_o   = ~valid_q[rptr_q];
  assign head_o    = mem_q[rptr_q];
  assign valid_o   = valid_q;
  assign entries_o = mem_q;

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      valid_q <= '0;
      mem_q   <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q]   <= push_entry_i;
        valid_q[wptr_q] <= 1'b1;
        wptr_q          <= wptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        valid_q[rptr_q] <= 1'b0;
        rptr_q          <= rptr_q + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: merges MEM/WB pipe writes with queued multi-cycle results.
// Optional WB_FWD_EN builds write-port forwarding compares; otherwise fwd_* are tied low.
module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  pipe_valid,
  input  logic [REG_ADDR_W-1:0] pipe_reg,
  input  logic [DATA_W-1:0]     pipe_data,
  input  logic                  mdu_valid,
  input  logic [REG_ADDR_W-1:0] mdu_reg,
  input  logic [DATA_W-1:0]     mdu_data,
  output logic                  mdu_ready,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] wr_reg,
  output logic [DATA_W-1:0]     wr_data,
  output logic [NUM_REGS-1:0]   busy_mask,
  output logic                  stall_req,
  input  logic [REG_ADDR_W-1:0] fwd_rs,
  input  logic [REG_ADDR_W-1:0] fwd_rt,
  output logic                  fwd_hit_rs,
  output logic                  fwd_hit_rt,
  output logic [DATA_W-1:0]     fwd_data
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  logic                       q_full;
  logic                       q_empty;
  wb_entry_t                  q_head;
  logic      [FIFO_DEPTH-1:0] q_valid;
  wb_entry_t [FIFO_DEPTH-1:0] q_entries;
  wb_entry_t                  push_entry;
  logic                       push;
  logic                       pop;
  logic                       pipe_write;

  logic                  ready_q;
  logic [CNT_W-1:0]      starve_q, starve_d;
  logic                  reg_write_q, reg_write_d;
  logic [REG_ADDR_W-1:0] wr_reg_q, wr_reg_d;
  logic [DATA_W-1:0]     wr_data_q, wr_data_d;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk          (clock),
    .rst_n        (reset_n),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .full_o       (q_full),
    .empty_o      (q_empty),
    .head_o       (q_head),
    .valid_o      (q_valid),
    .entries_o    (q_entries)
  );

  // ready_q keeps mdu_ready low through reset and the cycle it is released.
  assign mdu_ready  = ready_q & ~q_full;
  assign stall_req  = ~q_empty & (starve_q == CNT_W'(STARVE_MAX));
  assign pipe_write = pipe_valid & (pipe_reg != '0) & ~stall_req;
  assign pop        = ~q_empty & ~pipe_write;
  assign push       = mdu_valid & mdu_ready & (mdu_reg != '0);
  assign push_entry = '{reg_addr: mdu_reg, data: mdu_data};

  always_comb begin
    busy_mask = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (q_valid[i]) busy_mask[q_entries[i].reg_addr] = 1'b1;
    end
  end

  // Pipe wins unless starved; otherwise drain the queue head.
  always_comb begin
    reg_write_d = 1'b0;
    wr_reg_d    = '0;
    wr_data_d   = '0;
    starve_d    = starve_q;
    if (pipe_write) begin
      reg_write_d = 1'b1;
      wr_reg_d    = pipe_reg;
      wr_data_d   = pipe_data;
    end else if (pop) begin
      reg_write_d = 1'b1;
      wr_reg_d    = q_head.reg_addr;
      wr_data_d   = q_head.data;
    end
    if (q_empty || pop) begin
      starve_d = '0;
    end else if (starve_q != CNT_W'(STARVE_MAX)) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ready_q     <= 1'b0;
      starve_q    <= '0;
      reg_write_q <= 1'b0;
      wr_reg_q    <= '0;
      wr_data_q   <= '0;
    end else begin
      ready_q     <= 1'b1;
      starve_q    <= starve_d;
      reg_write_q <= reg_write_d;
      wr_reg_q    <= wr_reg_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign RegWrite = reg_write_q;
  assign wr_reg   = wr_reg_q;
  assign wr_data  = wr_data_q;

`ifdef WB_FWD_EN
  assign fwd_hit_rs = reg_write_q & (fwd_rs == wr_reg_q) & (fwd_rs != '0);
  assign fwd_hit_rt = reg_write_q & (fwd_rt == wr_reg_q) & (fwd_rt != '0);
  assign fwd_data   = (fwd_hit_rs | fwd_hit_rt) ? wr_data_q : '0;
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_rs, fwd_rt};
  assign fwd_hit_rs = 1'b0;
  assign fwd_hit_rt = 1'b0;
  assign fwd_data   = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter (FIFO_DEPTH=2, STARVE_MAX=4); honours WB_FWD_EN.
module tb_regfile_wb_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        pipe_valid = 1'b0;
  logic [4:0]  pipe_reg = '0;
  logic [31:0] pipe_data = '0;
  logic        mdu_valid = 1'b0;
  logic [4:0]  mdu_reg = '0;
  logic [31:0] mdu_data = '0;
  logic        mdu_ready;
  logic        RegWrite;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic [31:0] busy_mask;
  logic        stall_req;
  logic [4:0]  fwd_rs = '0;
  logic [4:0]  fwd_rt = '0;
  logic        fwd_hit_rs;
  logic        fwd_hit_rt;
  logic [31:0] fwd_data;

  int tests_run = 0;
  int tests_failed = 0;

  regfile_wb_arbiter #(.FIFO_DEPTH(2), .STARVE_MAX(4)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .pipe_valid (pipe_valid),
    .pipe_reg   (pipe_reg),
    .pipe_data  (pipe_data),
    .mdu_valid  (mdu_valid),
    .mdu_reg    (mdu_reg),
    .mdu_data   (mdu_data),
    .mdu_ready  (mdu_ready),
    .RegWrite   (RegWrite),
    .wr_reg     (wr_reg),
    .wr_data    (wr_data),
    .busy_mask  (busy_mask),
    .stall_req  (stall_req),
    .fwd_rs     (fwd_rs),
    .fwd_rt     (fwd_rt),
    .fwd_hit_rs (fwd_hit_rs),
    .fwd_hit_rt (fwd_hit_rt),
    .fwd_data   (fwd_data)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if (RegWrite !== 1'b0 || wr_reg !== 5'd0 || wr_data !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_write_port: RegWrite=%b wr_reg=%0d wr_data=%h, expected 0 0 0", RegWrite, wr_reg, wr_data);
    end
    tests_run++;
    if (busy_mask !== 32'd0 || stall_req !== 1'b0 || mdu_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_status: busy=%h stall=%b ready=%b, expected 0 0 0", busy_mask, stall_req, mdu_ready);
    end
    tests_run++;
    if (fwd_hit_rs !== 1'b0 || fwd_hit_rt !== 1'b0 || fwd_data !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_fwd: hit_rs=%b hit_rt=%b data=%h, expected 0 0 0", fwd_hit_rs, fwd_hit_rt, fwd_data);
    end
    tick();
    reset_n = 1'b1;
    tick();
    tests_run++;
    if (mdu_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release_ready: mdu_ready=%b, expected 1", mdu_ready);
    end
  endtask

  task automatic test_pipe();
    pipe_valid = 1'b1; pipe_reg = 5'd5; pipe_data = 32'hDEADBEEF;
    tick();
    tests_run++;
    if (RegWrite !== 1'b1 || wr_reg !== 5'd5 || wr_data !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL pipe_write: RegWrite=%b wr_reg=%0d wr_data=%h, expected 1 5 deadbeef", RegWrite, wr_reg, wr_data);
    end
    pipe_reg = 5'd0; pipe_data = 32'h12345678;
    tick();
    tests_run++;
    if (RegWrite !== 1'b0) begin
      tests_failed++;
      $display("FAIL pipe_reg0_dropped: RegWrite=%b, expected 0", RegWrite);
    end
    pipe_valid = 1'b0;
    tick();
    tests_run++;
    if (RegWrite !== 1'b0) begin
      tests_failed++;
      $display("FAIL pipe_idle: RegWrite=%b, expected 0", RegWrite);
    end
  endtask

  task automatic test_mdu_reg0();
    mdu_valid = 1'b1; mdu_reg = 5'd0; mdu_data = 32'h55;
    tick();
    mdu_valid = 1'b0;
    #1;
    tests_run++;
    if (busy_mask !== 32'd0 || mdu_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL mdu_reg0_consumed: busy=%h ready=%b, expected 0 1", busy_mask, mdu_ready);
    end
    tick();
    tests_run++;
    if (RegWrite !== 1'b0) begin
      tests_failed++;
      $display("FAIL mdu_reg0_no_write: RegWrite=%b, expected 0", RegWrite);
    end
  endtask

  task automatic test_drain();
    pipe_valid = 1'b1; pipe_reg = 5'd1; pipe_data = 32'hA1;
    mdu_valid = 1'b1; mdu_reg = 5'd7; mdu_data = 32'h11;
    tick();
    pipe_reg = 5'd2; pipe_data = 32'hA2;
    mdu_reg = 5'd9; mdu_data = 32'h22;
    #1;
    tests_run++;
    if (mdu_ready !== 1'b1 || busy_mask !== 32'h80 || wr_reg !== 5'd1) begin
      tests_failed++;
      $display("FAIL drain_one_queued: ready=%b busy=%h wr_reg=%0d, expected 1 80 1", mdu_ready, busy_mask, wr_reg);
    end
    tick();
    pipe_valid = 1'b0; mdu_valid = 1'b0;
    #1;
    tests_run++;
    if (mdu_ready !== 1'b0 || busy_mask !== 32'h280 || stall_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL drain_full: ready=%b busy=%h stall=%b, expected 0 280 0", mdu_ready, busy_mask, stall_req);
    end
    tick();
    tests_run++;
    if (RegWrite !== 1'b1 || wr_reg !== 5'd7 || wr_data !== 32'h11 || busy_mask !== 32'h200 || mdu_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL drain_first: RegWrite=%b wr_reg=%0d wr_data=%h busy=%h ready=%b, expected 1 7 11 200 1",
               RegWrite, wr_reg, wr_data, busy_mask, mdu_ready);
    end
    tick();
    tests_run++;
    if (RegWrite !== 1'b1 || wr_reg !== 5'd9 || wr_data !== 32'h22 || busy_mask !== 32'h0) begin
      tests_failed++;
      $display("FAIL drain_second: RegWrite=%b wr_reg=%0d wr_data=%h busy=%h, expected 1 9 22 0",
               RegWrite, wr_reg, wr_data, busy_mask);
    end
    tick();
    tests_run++;
    if (RegWrite !== 1'b0) begin
      tests_failed++;
      $display("FAIL drain_done: RegWrite=%b, expected 0", RegWrite);
    end
  endtask

  task automatic test_starve();
    pipe_valid = 1'b1; pipe_reg = 5'd4; pipe_data = 32'h44;
    mdu_valid = 1'b1; mdu_reg = 5'd3; mdu_data = 32'h33;
    tick();
    mdu_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      pipe_reg = 5'(10 + i); pipe_data = 32'(32'h100 + i);
      #1;
      tests_run++;
      if (stall_req !== 1'b0 || busy_mask !== 32'h8) begin
        tests_failed++;
        $display("FAIL starve_wait_%0d: stall=%b busy=%h, expected 0 8", i, stall_req, busy_mask);
      end
      tick();
      tests_run++;
      if (RegWrite !== 1'b1 || wr_reg !== 5'(10 + i) || wr_data !== 32'(32'h100 + i)) begin
        tests_failed++;
        $display("FAIL starve_pipe_%0d: RegWrite=%b wr_reg=%0d wr_data=%h, expected 1 %0d %h",
                 i, RegWrite, wr_reg, wr_data, 10 + i, 32'h100 + i);
      end
    end
    pipe_reg = 5'd20; pipe_data = 32'h200;
    #1;
    tests_run++;
    if (stall_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL starve_stall: stall=%b, expected 1", stall_req);
    end
    tick();
    tests_run++;
    if (RegWrite !== 1'b1 || wr_reg !== 5'd3 || wr_data !== 32'h33) begin
      tests_failed++;
      $display("FAIL starve_issue: RegWrite=%b wr_reg=%0d wr_data=%h, expected 1 3 33", RegWrite, wr_reg, wr_data);
    end
    pipe_reg = 5'd21; pipe_data = 32'h210;
    #1;
    tests_run++;
    if (stall_req !== 1'b0 || busy_mask !== 32'h0) begin
      tests_failed++;
      $display("FAIL starve_cleared: stall=%b busy=%h, expected 0 0", stall_req, busy_mask);
    end
    tick();
    pipe_valid = 1'b0;
    tests_run++;
    if (RegWrite !== 1'b1 || wr_reg !== 5'd21 || wr_data !== 32'h210) begin
      tests_failed++;
      $display("FAIL starve_resume: RegWrite=%b wr_reg=%0d wr_data=%h, expected 1 21 210", RegWrite, wr_reg, wr_data);
    end
    tick();
  endtask

  task automatic test_reset_midflight();
    pipe_valid = 1'b1; pipe_reg = 5'd1; pipe_data = 32'hB1;
    mdu_valid = 1'b1; mdu_reg = 5'd13; mdu_data = 32'hD13;
    tick();
    pipe_reg = 5'd2; pipe_data = 32'hB2;
    mdu_reg = 5'd14; mdu_data = 32'hD14;
    tick();
    pipe_valid = 1'b0; mdu_valid = 1'b0;
    #1;
    tests_run++;
    if (busy_mask !== 32'h6000) begin
      tests_failed++;
      $display("FAIL midflight_queued: busy=%h, expected 6000", busy_mask);
    end
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (RegWrite !== 1'b0 || wr_reg !== 5'd0 || wr_data !== 32'd0 || busy_mask !== 32'd0 ||
        stall_req !== 1'b0 || mdu_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL midflight_reset: RegWrite=%b wr_reg=%0d wr_data=%h busy=%h stall=%b ready=%b, expected all 0",
               RegWrite, wr_reg, wr_data, busy_mask, stall_req, mdu_ready);
    end
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    tests_run++;
    if (mdu_ready !== 1'b1 || busy_mask !== 32'd0) begin
      tests_failed++;
      $display("FAIL midflight_release: ready=%b busy=%h, expected 1 0", mdu_ready, busy_mask);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (RegWrite !== 1'b0) begin
        tests_failed++;
        $display("FAIL midflight_discard_%0d: RegWrite=%b wr_reg=%0d, expected RegWrite 0", i, RegWrite, wr_reg);
      end
    end
  endtask

  task automatic test_fwd();
    logic        exp_rs;
    logic        exp_rt;
    logic [31:0] exp_data;
    pipe_valid = 1'b1; pipe_reg = 5'd12; pipe_data = 32'hCAFEF00D;
    tick();
    pipe_valid = 1'b0;
    fwd_rs = 5'd12; fwd_rt = 5'd0;
    #1;
`ifdef WB_FWD_EN
    exp_rs = 1'b1; exp_rt = 1'b0; exp_data = 32'hCAFEF00D;
`else
    exp_rs = 1'b0; exp_rt = 1'b0; exp_data = 32'h0;
`endif
    tests_run++;
    if (fwd_hit_rs !== exp_rs || fwd_hit_rt !== exp_rt || fwd_data !== exp_data) begin
      tests_failed++;
      $display("FAIL fwd_rs_hit: hit_rs=%b hit_rt=%b data=%h, expected %b %b %h",
               fwd_hit_rs, fwd_hit_rt, fwd_data, exp_rs, exp_rt, exp_data);
    end
    fwd_rs = 5'd3; fwd_rt = 5'd12;
    #1;
`ifdef WB_FWD_EN
    exp_rs = 1'b0; exp_rt = 1'b1; exp_data = 32'hCAFEF00D;
`else
    exp_rs = 1'b0; exp_rt = 1'b0; exp_data = 32'h0;
`endif
    tests_run++;
    if (fwd_hit_rs !== exp_rs || fwd_hit_rt !== exp_rt || fwd_data !== exp_data) begin
      tests_failed++;
      $display("FAIL fwd_rt_hit: hit_rs=%b hit_rt=%b data=%h, expected %b %b %h",
               fwd_hit_rs, fwd_hit_rt, fwd_data, exp_rs, exp_rt, exp_data);
    end
    tick();
    tests_run++;
    if (fwd_hit_rs !== 1'b0 || fwd_hit_rt !== 1'b0 || fwd_data !== 32'd0) begin
      tests_failed++;
      $display("FAIL fwd_no_write: hit_rs=%b hit_rt=%b data=%h, expected 0 0 0", fwd_hit_rs, fwd_hit_rt, fwd_data);
    end
    fwd_rs = 5'd0; fwd_rt = 5'd0;
  endtask

  initial begin
    test_reset();
    test_pipe();
    test_mdu_reg0();
    test_drain();
    test_starve();
    test_reset_midflight();
    test_fwd();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
